// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MIO handshake: owns MAR/MDR, a word RAM
// and the memory-mapped LED/switch registers, answering each request after LATENCY cycles.
module lc3_mem_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned LATENCY  = 3,
   parameter logic [15:0] LED_ADDR = 16'hFE00,
   parameter logic [15:0] SW_ADDR  = 16'hFE02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ld_mar,
   input  logic        i_ld_mdr,
   input  logic        i_mio_en,
   input  logic        i_rw,
   input  logic [15:0] i_bus,
   input  logic [3:0]  i_sw,
   output logic [15:0] o_mdr,
   output logic        o_ready_bit,
   output logic        o_addr_err,
   output logic [3:0]  o_led
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

   state_t      state;
   logic [15:0] mar;
   logic [15:0] mdr;
   logic [15:0] snap_addr;
   logic [15:0] snap_data;
   logic        snap_rw;
   logic [3:0]  cnt;
   logic [3:0]  led;
   logic        ready;
   logic        addr_err;

   logic [15:0] mem [0:(1 << ADDR_W) - 1];

   logic [15:0] req_addr;
   logic        hit_led;
   logic        hit_sw;
   logic        hit_ram;
   logic [15:0] rd_data;

   function automatic logic in_ram(input logic [15:0] a);
      return 32'(a) < (32'd1 << ADDR_W);
   endfunction

   function automatic logic unmapped(input logic [15:0] a);
      return (a != LED_ADDR) && (a != SW_ADDR) && !in_ram(a);
   endfunction

   // A MAR load in the request cycle must steer that same request.
   assign req_addr = i_ld_mar ? i_bus : mar;

   always_comb begin
      hit_led = (snap_addr == LED_ADDR);
      hit_sw  = (snap_addr == SW_ADDR);
      hit_ram = in_ram(snap_addr) && !hit_led && !hit_sw;
      rd_data = '0;
      if (hit_led)
         rd_data = {12'h000, led};
      else if (hit_sw)
         rd_data = {12'h000, i_sw};
      else if (hit_ram)
         rd_data = mem[snap_addr[ADDR_W-1:0]];
   end

   // RAM is not reset; a reset returns state to IDLE, which blocks the commit.
   always_ff @(posedge clk) begin
      if (state == DONE && snap_rw && hit_ram)
         mem[snap_addr[ADDR_W-1:0]] <= snap_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mar       <= '0;
         mdr       <= '0;
         snap_addr <= '0;
         snap_data <= '0;
         snap_rw   <= 1'b0;
         cnt       <= '0;
         led       <= '0;
         ready     <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         ready    <= 1'b0;
         addr_err <= 1'b0;
         if (i_ld_mar)
            mar <= i_bus;
         if (i_ld_mdr && !i_mio_en)
            mdr <= i_bus;
         case (state)
            IDLE: begin
               if (i_mio_en) begin
                  snap_addr <= req_addr;
                  snap_data <= mdr;
                  snap_rw   <= i_rw;
                  cnt       <= 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state    <= DONE;
                     ready    <= 1'b1;
                     addr_err <= unmapped(req_addr);
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!i_mio_en) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state    <= DONE;
                     ready    <= 1'b1;
                     addr_err <= unmapped(snap_addr);
                  end
               end
            end
            DONE: begin
               if (snap_rw) begin
                  if (hit_led)
                     led <= snap_data[3:0];
               end else if (i_ld_mdr && i_mio_en) begin
                  mdr <= rd_data;
               end
               state <= RELEASE;
            end
            RELEASE: begin
               if (!i_mio_en)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_mdr       = mdr;
   assign o_ready_bit = ready;
   assign o_addr_err  = addr_err;
   assign o_led       = led;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: two instances (LATENCY 3 and 1) driven with
// directed and random accesses, expectations taken from a word-array reference model.
module tb_lc3_mem_responder;

   localparam int unsigned LAT0 = 3;
   localparam int unsigned LAT1 = 1;

   typedef struct {
      logic        err;
      logic [15:0] mdr;
      logic [3:0]  led;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ld_mar, ld_mdr, mio, rw;
   logic [1:0]  ready, aerr;
   logic [15:0] bus [2];
   logic [15:0] mdr [2];
   logic [3:0]  led [2];
   logic [3:0]  sw;

   logic [15:0] ram_m [2][1024];
   logic [3:0]  led_m [2];

   exp_t q0[$];
   exp_t q1[$];
   exp_t pexp [2];
   bit   pend [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lc3_mem_responder #(.ADDR_W(10), .LATENCY(LAT0), .LED_ADDR(16'hFE00), .SW_ADDR(16'hFE02)) u_dut0 (
      .clk(clk), .rst(rst), .i_ld_mar(ld_mar[0]), .i_ld_mdr(ld_mdr[0]), .i_mio_en(mio[0]),
      .i_rw(rw[0]), .i_bus(bus[0]), .i_sw(sw), .o_mdr(mdr[0]), .o_ready_bit(ready[0]),
      .o_addr_err(aerr[0]), .o_led(led[0])
   );

   lc3_mem_responder #(.ADDR_W(10), .LATENCY(LAT1), .LED_ADDR(16'hFE00), .SW_ADDR(16'hFE02)) u_dut1 (
      .clk(clk), .rst(rst), .i_ld_mar(ld_mar[1]), .i_ld_mdr(ld_mdr[1]), .i_mio_en(mio[1]),
      .i_rw(rw[1]), .i_bus(bus[1]), .i_sw(sw), .o_mdr(mdr[1]), .o_ready_bit(ready[1]),
      .o_addr_err(aerr[1]), .o_led(led[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Reference rules: LED and switch registers first, then 1024-word RAM, else unmapped.
   function automatic bit unmapped_f(input logic [15:0] a);
      return (a != 16'hFE00) && (a != 16'hFE02) && (a >= 16'h0400);
   endfunction

   function automatic logic [15:0] ref_rd(input int d, input logic [15:0] a);
      if (a == 16'hFE00) return {12'h000, led_m[d]};
      if (a == 16'hFE02) return {12'h000, sw};
      if (a < 16'h0400)  return ram_m[d][a[9:0]];
      return 16'h0000;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // mar_mode: 0 = load MAR in a prior cycle, 1 = load MAR in the request cycle, 2 = keep MAR
   task automatic access(input int d, input bit w, input logic [15:0] a, input logic [15:0] data,
                         input int mar_mode, input int hold, input logic [3:0] sw_val);
      exp_t e;
      int   n;
      int   lat;
      bit   timed_out;
      lat = (d == 0) ? LAT0 : LAT1;
      sw  = sw_val;
      if (mar_mode == 0) begin
         cyc(); ld_mar[d] = 1'b1; bus[d] = a;
      end
      if (w) begin
         cyc(); ld_mar[d] = 1'b0; ld_mdr[d] = 1'b1; bus[d] = data;
      end
      e.err = unmapped_f(a);
      if (w) begin
         if (a == 16'hFE00) led_m[d] = data[3:0];
         else if (a < 16'h0400) ram_m[d][a[9:0]] = data;
         e.mdr = data;
      end else begin
         e.mdr = ref_rd(d, a);
      end
      e.led = led_m[d];
      cyc();
      ld_mar[d] = (mar_mode == 1);
      bus[d]    = (mar_mode == 1) ? a : 16'($urandom);
      ld_mdr[d] = !w;
      mio[d]    = 1'b1;
      rw[d]     = w;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      n = 0;
      timed_out = 1'b0;
      forever begin
         @(posedge clk);
         n++;
         #1;
         // Inputs change freely once the request has been snapshotted.
         ld_mar[d] = 1'($urandom);
         bus[d]    = 16'($urandom);
         rw[d]     = 1'($urandom);
         if (w) ld_mdr[d] = 1'($urandom);
         @(negedge clk);
         if (ready[d]) break;
         if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d: no ready after %0d cycles, required %0d", d, n, lat);
            timed_out = 1'b1;
            break;
         end
      end
      if (!timed_out) chk($sformatf("latency_dut%0d", d), n, lat);
      repeat (hold) @(negedge clk);
      cyc();
      ld_mar[d] = 1'b0; ld_mdr[d] = 1'b0; mio[d] = 1'b0; rw[d] = 1'b0; bus[d] = '0;
      cyc();
   endtask

   task automatic abort_write(input logic [15:0] a, input logic [15:0] data);
      bit seen;
      cyc(); ld_mar[0] = 1'b1; bus[0] = a;
      cyc(); ld_mar[0] = 1'b0; ld_mdr[0] = 1'b1; bus[0] = data;
      cyc(); ld_mdr[0] = 1'b0; mio[0] = 1'b1; rw[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      mio[0] = 1'b0; rw[0] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ready[0]) seen = 1'b1;
      end
      chk("abort_no_ready", seen, 0);
      cyc();
   endtask

   task automatic reset_mid_wait(input logic [15:0] a, input logic [15:0] data);
      cyc(); ld_mar[0] = 1'b1; bus[0] = a;
      cyc(); ld_mar[0] = 1'b0; ld_mdr[0] = 1'b1; bus[0] = data;
      cyc(); ld_mdr[0] = 1'b0; mio[0] = 1'b1; rw[0] = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready, 2'b00);
      chk("rst_mdr0", mdr[0], 16'h0000);
      chk("rst_mdr1", mdr[1], 16'h0000);
      chk("rst_led0", led[0], 4'h0);
      chk("rst_led1", led[1], 4'h0);
      cyc(); mio[0] = 1'b0; rw[0] = 1'b0; bus[0] = '0;
      cyc(); rst = 1'b1;
      led_m[0] = 4'h0;
      led_m[1] = 4'h0;
      repeat (4) cyc();
   endtask

   function automatic logic [15:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0: return 16'hFE00;
         1: return 16'hFE02;
         2: return 16'($urandom_range(16'h0400, 16'hFDFF));
         3: return 16'h03FF;
         default: return 16'($urandom_range(0, 31));
      endcase
   endfunction

   // Scoreboard monitor: pops one expectation per ready pulse, checks MDR/LED after the commit edge.
   always @(negedge clk) begin
      exp_t e;
      bit   got;
      if (rst === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            if (pend[d]) begin
               chk($sformatf("mdr_dut%0d", d), mdr[d], pexp[d].mdr);
               chk($sformatf("led_dut%0d", d), led[d], pexp[d].led);
               pend[d] = 1'b0;
            end
            got = 1'b0;
            if (ready[d]) begin
               if (d == 0 && q0.size() > 0) begin
                  e = q0.pop_front(); got = 1'b1;
               end else if (d == 1 && q1.size() > 0) begin
                  e = q1.pop_front(); got = 1'b1;
               end
               if (got) begin
                  chk($sformatf("addr_err_dut%0d", d), aerr[d], e.err);
                  pexp[d] = e;
                  pend[d] = 1'b1;
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ready dut%0d: ready=1 required 0 (t=%0t)", d, $time);
               end
            end else if (aerr[d]) begin
               checks++;
               errors++;
               $display("FAIL stray_addr_err dut%0d: addr_err=1 required 0 (t=%0t)", d, $time);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst    = 1'b0;
      ld_mar = '0; ld_mdr = '0; mio = '0; rw = '0;
      bus[0] = '0; bus[1] = '0;
      sw     = '0;
      led_m[0] = '0; led_m[1] = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ready", ready, 2'b00);
      chk("reset_err", aerr, 2'b00);
      chk("reset_mdr0", mdr[0], 16'h0000);
      chk("reset_led0", led[0], 4'h0);
      chk("reset_mdr1", mdr[1], 16'h0000);
      chk("reset_led1", led[1], 4'h0);
      cyc();
      rst = 1'b1;
      cyc();

      for (int d = 0; d < 2; d++) begin
         for (int unsigned a = 0; a < 32; a++)
            access(d, 1'b1, 16'(a), 16'($urandom), 0, 0, 4'h0);
         access(d, 1'b1, 16'h03FF, 16'($urandom), 0, 0, 4'h0);
      end

      access(0, 1'b1, 16'h0005, 16'h1234, 0, 0, 4'h0);
      access(0, 1'b0, 16'h0005, 16'h0000, 0, 0, 4'h0);
      access(0, 1'b1, 16'hFE00, 16'h000A, 0, 0, 4'h0);
      access(0, 1'b0, 16'hFE02, 16'h0000, 0, 0, 4'h6);
      access(0, 1'b1, 16'hFE02, 16'h0003, 0, 0, 4'h6);
      access(0, 1'b0, 16'hFE00, 16'h0000, 0, 0, 4'h0);
      access(0, 1'b1, 16'h8000, 16'hBEEF, 0, 0, 4'h0);
      access(0, 1'b0, 16'h8000, 16'h0000, 0, 0, 4'h0);
      access(0, 1'b1, 16'h0400, 16'h1111, 0, 0, 4'h0);
      access(0, 1'b0, 16'h03FF, 16'h0000, 0, 0, 4'h0);

      abort_write(16'h0010, 16'h5555);
      access(0, 1'b0, 16'h0010, 16'h0000, 0, 0, 4'h0);
      access(0, 1'b0, 16'h0007, 16'h0000, 0, 10, 4'h0);

      reset_mid_wait(16'h0011, 16'hA5A5);
      access(0, 1'b0, 16'h0000, 16'h0000, 2, 0, 4'h0);
      access(0, 1'b0, 16'h0011, 16'h0000, 0, 0, 4'h0);

      access(1, 1'b1, 16'h0003, 16'hC0DE, 0, 0, 4'h0);
      access(1, 1'b1, 16'h0007, 16'h7777, 0, 0, 4'h0);
      access(1, 1'b0, 16'h0003, 16'h0000, 1, 0, 4'h0);
      access(1, 1'b1, 16'h0004, 16'h4444, 1, 2, 4'h0);
      access(1, 1'b0, 16'h0004, 16'h0000, 0, 0, 4'h0);

      for (int i = 0; i < 150; i++) begin
         access($urandom_range(0, 1), 1'($urandom), pick_addr(), 16'($urandom),
                $urandom_range(0, 1), $urandom_range(0, 3), 4'($urandom));
      end

      repeat (5) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
